// File: rtl/bin_morph_ctrl.sv
// bin_morph_ctrl
//    Frame-synchronous controller for a two-stage cascade of binary
//    erosion/dilation cores. A single morphology request (bypass, erode,
//    dilate, open, close) is taken over a valid/ready port and held as
//    pending. It is applied to the stage controls only at the next input
//    start-of-frame, so a frame never sees a configuration change partway
//    through. A frame budget returns the cascade to bypass when it runs out,
//    and completion is flagged at the output end-of-frame.
//
// Ports
//    clk, rst            clock, synchronous active-high reset
//    in_vsync            input frame vsync (high for the whole frame)
//    out_vsync           vsync seen at the output of stage 2
//    cfg_valid/ready     request handshake; ready is low while a request is pending
//    cfg_op              0 bypass, 1 erode, 2 dilate, 3 open, 4 close, 5-7 illegal
//    cfg_thresh1/2       stage thresholds, clamped to MAX_THRESH
//    cfg_frames          frame budget, 0 = run continuously
//    cfg_abort           drop the pending request, go to bypass at next sof
//    s1_*/s2_*           stage enable, mode (0 erode, 1 dilate), threshold
//    busy                running an op or holding a pending request
//    cfg_err             1-cycle pulse after an illegal op is accepted
//    done                1-cycle pulse at output eof of the last budgeted frame
//    frames_left         frames remaining after the current one
//    out_frame_cnt       processed frames completed at the output (wraps)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cascade in bypass, no op active
// RUN     | an op is applied; budget counted at each sof unless continuous

module bin_morph_ctrl #(
   parameter int CNT_W      = 8,
   parameter int MAX_THRESH = 9,
   parameter int DEF_THRESH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vsync,
   input  logic             out_vsync,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [2:0]       cfg_op,
   input  logic [3:0]       cfg_thresh1,
   input  logic [3:0]       cfg_thresh2,
   input  logic [CNT_W-1:0] cfg_frames,
   input  logic             cfg_abort,
   output logic             s1_en,
   output logic             s2_en,
   output logic             s1_mode,
   output logic             s2_mode,
   output logic [3:0]       s1_thresh,
   output logic [3:0]       s2_thresh,
   output logic             busy,
   output logic             cfg_err,
   output logic             done,
   output logic [CNT_W-1:0] frames_left,
   output logic [15:0]      out_frame_cnt
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic       en1;
      logic       mode1;
      logic [3:0] thr1;
      logic       en2;
      logic       mode2;
      logic [3:0] thr2;
   } stage_cfg_t;

   localparam logic [3:0] MAX_T = 4'(MAX_THRESH);
   localparam logic [3:0] DEF_T = 4'(DEF_THRESH);

   localparam logic [2:0] OP_BYPASS = 3'd0;
   localparam logic [2:0] OP_ERODE  = 3'd1;
   localparam logic [2:0] OP_DILATE = 3'd2;
   localparam logic [2:0] OP_OPEN   = 3'd3;
   localparam logic [2:0] OP_CLOSE  = 3'd4;

   localparam stage_cfg_t BYPASS_CFG = '{
      en1: 1'b0, mode1: 1'b0, thr1: DEF_T,
      en2: 1'b0, mode2: 1'b0, thr2: DEF_T
   };

   // A disabled stage keeps mode 0 and the default threshold so that the
   // cores see the same idle values regardless of which op left them off.
   function automatic stage_cfg_t map_op(input logic [2:0] op,
                                         input logic [3:0] t1,
                                         input logic [3:0] t2);
      stage_cfg_t c;
      c = BYPASS_CFG;
      case (op)
         OP_ERODE: begin
            c.en1   = 1'b1;
            c.mode1 = 1'b0;
            c.thr1  = t1;
         end
         OP_DILATE: begin
            c.en1   = 1'b1;
            c.mode1 = 1'b1;
            c.thr1  = t1;
         end
         OP_OPEN: begin
            c.en1   = 1'b1;
            c.mode1 = 1'b0;
            c.thr1  = t1;
            c.en2   = 1'b1;
            c.mode2 = 1'b1;
            c.thr2  = t2;
         end
         OP_CLOSE: begin
            c.en1   = 1'b1;
            c.mode1 = 1'b1;
            c.thr1  = t1;
            c.en2   = 1'b1;
            c.mode2 = 1'b0;
            c.thr2  = t2;
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [3:0] clamp_thr(input logic [3:0] t);
      return (t > MAX_T) ? MAX_T : t;
   endfunction

   state_t           state_q, state_d;
   stage_cfg_t       stg_q, stg_d;
   logic             in_vsync_q, out_vsync_q;
   logic             pend_valid_q, pend_valid_d;
   logic [2:0]       pend_op_q, pend_op_d;
   logic [3:0]       pend_t1_q, pend_t1_d;
   logic [3:0]       pend_t2_q, pend_t2_d;
   logic [CNT_W-1:0] pend_frames_q, pend_frames_d;
   logic [CNT_W-1:0] left_q, left_d;
   logic             cont_q, cont_d;
   logic             last_q, last_d;
   logic             abort_q, abort_d;
   logic             run_frame_q, run_frame_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             done_q, done_d;

   logic             sof;
   logic             out_eof;
   logic             hs;

   assign sof     = in_vsync & ~in_vsync_q;
   assign out_eof = ~out_vsync & out_vsync_q;
   assign hs      = cfg_valid & ~pend_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         stg_q         <= BYPASS_CFG;
         in_vsync_q    <= 1'b0;
         out_vsync_q   <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_op_q     <= OP_BYPASS;
         pend_t1_q     <= '0;
         pend_t2_q     <= '0;
         pend_frames_q <= '0;
         left_q        <= '0;
         cont_q        <= 1'b0;
         last_q        <= 1'b0;
         abort_q       <= 1'b0;
         run_frame_q   <= 1'b0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         stg_q         <= stg_d;
         in_vsync_q    <= in_vsync;
         out_vsync_q   <= out_vsync;
         pend_valid_q  <= pend_valid_d;
         pend_op_q     <= pend_op_d;
         pend_t1_q     <= pend_t1_d;
         pend_t2_q     <= pend_t2_d;
         pend_frames_q <= pend_frames_d;
         left_q        <= left_d;
         cont_q        <= cont_d;
         last_q        <= last_d;
         abort_q       <= abort_d;
         run_frame_q   <= run_frame_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      stg_d         = stg_q;
      pend_valid_d  = pend_valid_q;
      pend_op_d     = pend_op_q;
      pend_t1_d     = pend_t1_q;
      pend_t2_d     = pend_t2_q;
      pend_frames_d = pend_frames_q;
      left_d        = left_q;
      cont_d        = cont_q;
      last_d        = last_q;
      abort_d       = abort_q;
      run_frame_d   = run_frame_q;
      cnt_d         = cnt_q;
      err_d         = 1'b0;
      done_d        = 1'b0;

      // run_frame_q remembers whether the frame now draining at the output
      // was started in RUN.
      if (out_eof && run_frame_q) begin
         cnt_d = cnt_q + 16'd1;
         if (last_q) begin
            done_d = 1'b1;
            last_d = 1'b0;
         end
      end

      if (sof) begin
         if (abort_q) begin
            state_d = ST_IDLE;
            stg_d   = BYPASS_CFG;
            abort_d = 1'b0;
            last_d  = 1'b0;
            left_d  = '0;
            cont_d  = 1'b0;
         end else if (pend_valid_q && !cfg_abort) begin
            stg_d        = map_op(pend_op_q, pend_t1_q, pend_t2_q);
            pend_valid_d = 1'b0;
            cont_d       = (pend_frames_q == '0);
            last_d       = ~cont_d & (pend_frames_q == CNT_W'(1));
            if (pend_op_q != OP_BYPASS) begin
               state_d = ST_RUN;
               left_d  = cont_d ? '0 : pend_frames_q - CNT_W'(1);
            end else begin
               state_d = ST_IDLE;
               left_d  = '0;
            end
         end else if (state_q == ST_RUN && !cont_q) begin
            if (left_q == '0) begin
               state_d = ST_IDLE;
               stg_d   = BYPASS_CFG;
            end else begin
               left_d = left_q - CNT_W'(1);
               if (left_q == CNT_W'(1)) last_d = 1'b1;
            end
         end
         run_frame_d = (state_d == ST_RUN);
      end

      // Abort beats a same-cycle handshake: the request is simply dropped.
      if (cfg_abort) begin
         pend_valid_d = 1'b0;
         abort_d      = 1'b1;
      end else if (hs) begin
         if (cfg_op <= OP_CLOSE) begin
            pend_valid_d  = 1'b1;
            pend_op_d     = cfg_op;
            pend_t1_d     = clamp_thr(cfg_thresh1);
            pend_t2_d     = clamp_thr(cfg_thresh2);
            pend_frames_d = cfg_frames;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_comb begin
      cfg_ready     = ~pend_valid_q;
      busy          = (state_q == ST_RUN) | pend_valid_q;
      s1_en         = stg_q.en1;
      s1_mode       = stg_q.mode1;
      s1_thresh     = stg_q.thr1;
      s2_en         = stg_q.en2;
      s2_mode       = stg_q.mode2;
      s2_thresh     = stg_q.thr2;
      cfg_err       = err_q;
      done          = done_q;
      frames_left   = left_q;
      out_frame_cnt = cnt_q;
   end

endmodule

// File: tb/tb_bin_morph_ctrl.sv
module tb_bin_morph_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_vsync, out_vsync;
   logic        cfg_valid, cfg_ready, cfg_abort;
   logic [2:0]  cfg_op;
   logic [3:0]  cfg_thresh1, cfg_thresh2;
   logic [7:0]  cfg_frames;
   logic        s1_en, s2_en, s1_mode, s2_mode;
   logic [3:0]  s1_thresh, s2_thresh;
   logic        busy, cfg_err, done;
   logic [7:0]  frames_left;
   logic [15:0] out_frame_cnt;

   bin_morph_ctrl #(.CNT_W(8), .MAX_THRESH(9), .DEF_THRESH(3)) dut (
      .clk(clk), .rst(rst), .in_vsync(in_vsync), .out_vsync(out_vsync),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
      .cfg_thresh1(cfg_thresh1), .cfg_thresh2(cfg_thresh2),
      .cfg_frames(cfg_frames), .cfg_abort(cfg_abort),
      .s1_en(s1_en), .s2_en(s2_en), .s1_mode(s1_mode), .s2_mode(s2_mode),
      .s1_thresh(s1_thresh), .s2_thresh(s2_thresh), .busy(busy),
      .cfg_err(cfg_err), .done(done), .frames_left(frames_left),
      .out_frame_cnt(out_frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame-level reference: a pending slot, the applied stage setup and the
   // budget, advanced by the rules at each start/end of frame.
   bit m_pend, m_run, m_cont, m_last, m_abort, m_run_frame, m_prev_in, m_prev_out;
   int m_p_op, m_p_t1, m_p_t2, m_p_fr, m_left, m_cnt;
   int e_en1, e_md1, e_t1, e_en2, e_md2, e_t2;
   bit e_err, e_done;
   logic [2:0] dly;
   int n_done_seen = 0;
   int n_err_seen  = 0;

   int arm_at = -1;
   bit arm_abort;
   int arm_op, arm_t1, arm_t2, arm_fr;

   task automatic apply_op(input int op, input int t1, input int t2);
      e_en1 = (op >= 1 && op <= 4);
      e_md1 = (op == 2 || op == 4);
      e_en2 = (op == 3 || op == 4);
      e_md2 = (op == 3);
      e_t1  = e_en1 ? t1 : 3;
      e_t2  = e_en2 ? t2 : 3;
   endtask

   task automatic model_reset();
      m_pend = 0; m_run = 0; m_cont = 0; m_last = 0; m_abort = 0;
      m_run_frame = 0; m_prev_in = 0; m_prev_out = 0;
      m_left = 0; m_cnt = 0;
      apply_op(0, 0, 0);
   endtask

   task automatic step();
      bit iv, ov, cv, ca, sof, eof, hs;
      int op, t1, t2, fr;
      iv = in_vsync; ov = out_vsync; cv = cfg_valid; ca = cfg_abort;
      op = cfg_op; t1 = cfg_thresh1; t2 = cfg_thresh2; fr = cfg_frames;
      @(posedge clk);
      #1;
      e_err = 0;
      e_done = 0;
      if (rst) begin
         model_reset();
      end else begin
         sof = iv && !m_prev_in;
         eof = !ov && m_prev_out;
         hs  = cv && !m_pend;
         if (eof && m_run_frame) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (m_last) begin
               e_done = 1;
               m_last = 0;
            end
         end
         if (sof) begin
            if (m_abort) begin
               m_run = 0; m_abort = 0; m_last = 0; m_left = 0; m_cont = 0;
               apply_op(0, 0, 0);
            end else if (m_pend && !ca) begin
               apply_op(m_p_op, m_p_t1, m_p_t2);
               m_pend = 0;
               m_cont = (m_p_fr == 0);
               m_last = !m_cont && (m_p_fr == 1);
               m_run  = (m_p_op != 0);
               m_left = (m_run && !m_cont) ? m_p_fr - 1 : 0;
            end else if (m_run && !m_cont) begin
               if (m_left == 0) begin
                  m_run = 0;
                  apply_op(0, 0, 0);
               end else begin
                  m_left--;
                  if (m_left == 0) m_last = 1;
               end
            end
            m_run_frame = m_run;
         end
         if (ca) begin
            m_pend = 0;
            m_abort = 1;
         end else if (hs) begin
            if (op <= 4) begin
               m_pend = 1;
               m_p_op = op;
               m_p_t1 = (t1 > 9) ? 9 : t1;
               m_p_t2 = (t2 > 9) ? 9 : t2;
               m_p_fr = fr;
            end else begin
               e_err = 1;
            end
         end
         m_prev_in  = iv;
         m_prev_out = ov;
         if (hs || ca) cfg_valid = 0;
         cfg_abort = 0;
      end
      chk("ready", cfg_ready, !m_pend);
      chk("busy", busy, m_run || m_pend);
      chk("s1_en", s1_en, e_en1);
      chk("s1_mode", s1_mode, e_md1);
      chk("s1_thr", s1_thresh, e_t1);
      chk("s2_en", s2_en, e_en2);
      chk("s2_mode", s2_mode, e_md2);
      chk("s2_thr", s2_thresh, e_t2);
      chk("f_left", frames_left, m_left);
      chk("cfg_err", cfg_err, e_err);
      chk("done", done, e_done);
      chk("ofc", out_frame_cnt, m_cnt);
      if (done === 1'b1) n_done_seen++;
      if (cfg_err === 1'b1) n_err_seen++;
      // stage-2 output vsync trails the input by three cycles
      dly = {dly[1:0], iv};
      out_vsync = dly[2];
   endtask

   task automatic frame(input int act, input int blank);
      for (int i = 0; i < act + blank; i++) begin
         in_vsync = (i < act);
         if (i == arm_at) begin
            if (arm_abort) begin
               cfg_abort = 1;
            end else begin
               cfg_valid = 1; cfg_op = 3'(arm_op);
               cfg_thresh1 = 4'(arm_t1); cfg_thresh2 = 4'(arm_t2);
               cfg_frames = 8'(arm_fr);
            end
            arm_at = -1;
         end
         step();
      end
   endtask

   task automatic arm_req(input int at, input int op, input int t1, input int t2, input int fr);
      arm_at = at; arm_abort = 0;
      arm_op = op; arm_t1 = t1; arm_t2 = t2; arm_fr = fr;
   endtask

   initial begin
      int act, blank;
      rst = 1; in_vsync = 0; out_vsync = 0; dly = '0;
      cfg_valid = 0; cfg_abort = 0; cfg_op = 0;
      cfg_thresh1 = 0; cfg_thresh2 = 0; cfg_frames = 0;
      arm_abort = 0;
      model_reset();
      repeat (3) step();
      rst = 0;

      repeat (3) frame(12, 10);
      chk("idle_en", s1_en, 0);
      chk("idle_thr", s1_thresh, 3);
      chk("idle_ofc", out_frame_cnt, 0);
      chk("idle_busy", busy, 0);

      arm_req(5, 3, 4, 2, 2);
      frame(12, 10);
      chk("open_wait_en", s1_en, 0);
      frame(12, 10);
      chk("open_s1", {s1_en, s1_mode, s1_thresh}, {1'b1, 1'b0, 4'd4});
      chk("open_s2", {s2_en, s2_mode, s2_thresh}, {1'b1, 1'b1, 4'd2});
      repeat (2) frame(12, 10);
      chk("open_ofc", out_frame_cnt, 2);
      chk("open_done", n_done_seen, 1);
      chk("open_byp", s1_en, 0);

      arm_req(4, 1, 12, 0, 0);
      frame(12, 10);
      repeat (5) frame(12, 10);
      chk("cont_thr", s1_thresh, 9);
      chk("cont_left", frames_left, 0);
      chk("cont_done", n_done_seen, 1);
      chk("cont_busy", busy, 1);

      arm_req(6, 6, 1, 1, 1);
      frame(12, 10);
      chk("ill_err", n_err_seen, 1);
      chk("ill_en", s1_en, 1);

      arm_req(3, 2, 5, 0, 3);
      frame(12, 10);
      cfg_valid = 1; cfg_op = 4; cfg_thresh1 = 7; cfg_thresh2 = 15; cfg_frames = 1;
      step();
      chk("stall_rdy", cfg_ready, 0);
      frame(12, 10);
      chk("stall_acc", cfg_valid, 0);
      repeat (2) frame(12, 10);

      arm_req(2, 1, 5, 5, 0);
      repeat (2) frame(12, 10);
      arm_at = 4; arm_abort = 1;
      frame(12, 10);
      chk("abort_keep", s1_en, 1);
      frame(12, 10);
      chk("abort_busy", busy, 0);
      chk("abort_en", s1_en, 0);

      for (int f = 0; f < 40; f++) begin
         act   = int'($urandom_range(8, 20));
         blank = int'($urandom_range(8, 14));
         if (cfg_valid == 0) begin
            if ($urandom_range(0, 9) == 0) begin
               arm_at = int'($urandom_range(1, act + blank - 1));
               arm_abort = 1;
            end else if ($urandom_range(0, 1) == 1) begin
               arm_req(int'($urandom_range(0, act + blank - 1)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
            end
         end
         frame(act, blank);
      end
      for (int f = 0; f < 3 && cfg_valid; f++) frame(12, 10);
      chk("final_req", cfg_valid, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
